// File: rtl/clock_divider_pkg.sv
// Shared mode encodings, reset divide value and shadow-register layout for the divider.
// No logic of its own.
package clock_divider_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int DIV_W = 28;
    localparam logic [DIV_W-1:0] DEFAULT_DIV = 28'd24_999_999;

    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic             mode;
        logic             pending;
    } shadow_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: counter, live/shadow divide registers, registered level/tick outputs.
// Outputs change one cycle after terminal count; a new config waits in the shadow until applied.
module clock_divider_channel
    import clock_divider_pkg::*;
#(
    parameter int               CNT_W    = 28,
    parameter logic [CNT_W-1:0] INIT_DIV = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
    output logic             pending,
    output logic             level,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic             mode;
    shadow_t          shadow;
    logic             tc;

    assign tc      = enable && (cnt == div);
    assign pending = shadow.pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            div    <= INIT_DIV;
            mode   <= MODE_TOGGLE;
            level  <= 1'b1;
            tick   <= 1'b0;
            shadow <= '0;
        end else begin
            if (sync) begin
                cnt   <= '0;
                level <= 1'b1;
                tick  <= 1'b0;
                if (shadow.pending) begin
                    div  <= CNT_W'(shadow.div);
                    mode <= shadow.mode;
                end
            end else if (!enable) begin
                tick <= 1'b0;
                if (shadow.pending) begin
                    cnt  <= '0;
                    div  <= CNT_W'(shadow.div);
                    mode <= shadow.mode;
                end
            end else if (tc) begin
                cnt <= '0;
                // The TC event itself is rendered in the mode that was live when it occurred.
                if (mode == MODE_PULSE) begin
                    tick <= 1'b1;
                end else begin
                    tick  <= 1'b0;
                    level <= !level;
                end
                if (shadow.pending) begin
                    div  <= CNT_W'(shadow.div);
                    mode <= shadow.mode;
                end
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end

            // A write is only accepted while nothing is pending, so it never races an apply.
            if (wr) begin
                shadow <= '{div: DIV_W'(wr_div), mode: wr_mode, pending: 1'b1};
            end else if (sync || !enable || tc) begin
                shadow.pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// NUM_CH programmable clock dividers with a shared valid/ready config port.
// cfg_ready drops only for a channel whose previous write has not yet been applied.
module clock_divider_multi
    import clock_divider_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 28,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(clock_divider_pkg::DEFAULT_DIV),
    parameter int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    output logic [NUM_CH-1:0] out_level,
    output logic [NUM_CH-1:0] out_tick
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr;

    // Out-of-range channel selects fall through with ready high and are silently dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pending[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));

        clock_divider_channel #(
            .CNT_W    (CNT_W),
            .INIT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .enable  (enable[g]),
            .sync    (sync),
            .wr      (wr[g]),
            .wr_div  (cfg_div),
            .wr_mode (cfg_mode),
            .pending (pending[g]),
            .level   (out_level[g]),
            .tick    (out_tick[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed scoreboard bench for clock_divider_multi with DEFAULT_DIV = 3.
module tb_clock_divider_multi;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  enable;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [27:0] cfg_div;
    logic        cfg_mode;
    logic [3:0]  out_level;
    logic [3:0]  out_tick;

    clock_divider_multi #(
        .NUM_CH      (4),
        .CNT_W       (28),
        .DEFAULT_DIV (28'd3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .out_level (out_level),
        .out_tick  (out_tick)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   failed = 0;

    // Monitor: compares every expectation due this cycle, away from the active edge.
    always @(negedge clock) begin
        logic [3:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                case (sb[i].kind)
                    0:       act = out_level;
                    1:       act = out_tick;
                    default: act = {3'b000, cfg_ready};
                endcase
                tests++;
                if (act !== sb[i].val) begin
                    failed++;
                    $display("FAIL %s cyc=%0d got=%b want=%b", sb[i].name, cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic push(input string nm, input int kind, input logic [3:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic exp_out(input string nm, input logic [3:0] lv, input logic [3:0] tk);
        push({nm, "_level"}, 0, lv);
        push({nm, "_tick"}, 1, tk);
    endtask

    task automatic exp_rdy(input string nm, input logic r);
        push(nm, 2, {3'b000, r});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 4'b0000;
        sync      = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 28'd0;
        cfg_mode  = 1'b0;
        step();
        step();
        exp_out("reset", 4'b1111, 4'b0000);
        exp_rdy("reset_rdy", 1'b1);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic lv0;
        logic lv3;
        logic tk3;

        // Default divide of 3: ch0 level flips every 4 cycles.
        do_reset();
        enable = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_out("t1_div3", {3'b111, ((k / 4) % 2) == 0}, 4'b0000);
        end

        // ch2 programmed to div 1 PULSE while disabled, then enabled.
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 28'd1; cfg_mode = 1'b1;
        exp_rdy("t2_rdy_free", 1'b1);
        step();
        cfg_valid = 1'b0;
        exp_rdy("t2_rdy_pending", 1'b0);
        step();
        exp_rdy("t2_rdy_applied", 1'b1);
        enable = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_out("t2_pulse", 4'b1111, {1'b0, (k % 2) == 0, 2'b00});
        end

        // ch0 retimed from 3 to 7 mid-count; second ch0 write stalls, ch1 write accepted.
        do_reset();
        enable = 4'b0001;
        for (int k = 1; k <= 20; k++) begin
            step();
            lv0 = (k < 4) ? 1'b1 : ((((k - 4) / 8) % 2) == 1);
            exp_out("t3_retime", {3'b111, lv0}, 4'b0000);
            case (k)
                1: begin
                    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 28'd7; cfg_mode = 1'b0;
                    exp_rdy("t3_rdy_first", 1'b1);
                end
                2: begin
                    cfg_div = 28'd9;
                    exp_rdy("t3_rdy_stall", 1'b0);
                end
                3: begin
                    cfg_ch = 2'd1; cfg_div = 28'd5;
                    exp_rdy("t3_rdy_other", 1'b1);
                end
                4: begin
                    cfg_valid = 1'b0; cfg_ch = 2'd0;
                    exp_rdy("t3_rdy_after_tc", 1'b1);
                end
                default: ;
            endcase
        end

        // ch3 div 0: toggle every cycle, then switch to PULSE for a continuous tick.
        do_reset();
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 28'd0; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        step();
        enable = 4'b1000;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k <= 8) begin
                lv3 = ((k % 2) == 0);
                tk3 = 1'b0;
            end else begin
                lv3 = 1'b1;
                tk3 = 1'b1;
            end
            exp_out("t4_div0", {lv3, 3'b111}, {tk3, 3'b000});
            if (k == 6) begin
                cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 28'd0; cfg_mode = 1'b1;
            end
            if (k == 7) cfg_valid = 1'b0;
        end

        // sync with ch1 holding a pending div of 5.
        do_reset();
        enable = 4'b0001;
        step();
        step();
        enable = 4'b0011;
        step();
        exp_out("t5_pre", 4'b1111, 4'b0000);
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 28'd5; cfg_mode = 1'b0;
        step();
        exp_out("t5_pre_tc", 4'b1110, 4'b0000);
        cfg_valid = 1'b0;
        exp_rdy("t5_rdy_pending", 1'b0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        exp_out("t5_sync", 4'b1111, 4'b0000);
        exp_rdy("t5_rdy_applied", 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            exp_out("t5_after", {2'b11, ((k / 6) % 2) == 0, ((k / 4) % 2) == 0}, 4'b0000);
        end

        // Disable ch0 at count 2 with level low, resume, then reset mid-count.
        do_reset();
        enable = 4'b0001;
        for (int k = 1; k <= 6; k++) step();
        exp_out("t6_run", 4'b1110, 4'b0000);
        enable = 4'b0000;
        for (int j = 1; j <= 10; j++) begin
            step();
            exp_out("t6_frozen", 4'b1110, 4'b0000);
        end
        enable = 4'b0001;
        step();
        exp_out("t6_resume", 4'b1110, 4'b0000);
        step();
        exp_out("t6_resume_tc", 4'b1111, 4'b0000);
        for (int k = 1; k <= 4; k++) step();
        exp_out("t6_low_again", 4'b1110, 4'b0000);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_out("t6_reset", 4'b1111, 4'b0000);
        exp_rdy("t6_reset_rdy", 1'b1);

        step();
        step();
        if (sb.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
